// File: rtl/router_fifo.sv
// Output buffer for one router port: a DEPTH-entry FIFO of {header flag, byte} words
// with a packet counter that pulses pkt_done as each packet's parity byte is read out.
module router_fifo #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic [6:0]       pkt_cnt,
    output logic             pkt_done
);

    logic [WIDTH:0]   mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
    logic             lfd_q;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [6:0]       pkt_cnt_q, pkt_cnt_d;
    logic             pkt_done_q, pkt_done_d;
    logic             flush;
    logic             do_write;
    logic             do_read;
    logic [WIDTH:0]   rd_word;

    assign flush    = reset || soft_reset;
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                      (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign do_write = write_enb && !full;
    assign do_read  = read_enb && !empty;
    assign rd_word  = mem[rd_ptr_q[ADDR_W-1:0]];

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        pkt_cnt_d  = pkt_cnt_q;
        pkt_done_d = 1'b0;
        if (do_write) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_read) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            data_out_d = rd_word[WIDTH-1:0];
            // Header reload counts payload plus parity; a counter already at zero ignores orphan bytes.
            if (rd_word[WIDTH]) begin
                pkt_cnt_d = {1'b0, rd_word[7:2]} + 7'd1;
            end else if (pkt_cnt_q != 7'd0) begin
                pkt_cnt_d  = pkt_cnt_q - 7'd1;
                pkt_done_d = (pkt_cnt_q == 7'd1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            lfd_q      <= 1'b0;
            data_out_q <= '0;
            pkt_cnt_q  <= '0;
            pkt_done_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            lfd_q      <= lfd_state;
            data_out_q <= data_out_d;
            pkt_cnt_q  <= pkt_cnt_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    // NOTE: the storage array has no reset; stale contents are unreachable while the pointers say empty.
    always_ff @(posedge clk) begin
        if (do_write && !flush) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= {lfd_q, data_in};
        end
    end

    assign data_out = data_out_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign pkt_done = pkt_done_q;

endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: a queue scoreboard of {flag, byte} entries predicts
// data_out, pkt_cnt, pkt_done and the flags after every cycle.
module tb_router_fifo;

    logic       clk;
    logic       reset;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic [6:0] pkt_cnt;
    logic       pkt_done;

    int total = 0;
    int bad   = 0;

    logic [8:0] sb [$];
    logic [7:0] exp_data;
    logic [6:0] exp_cnt;
    logic       exp_done;
    logic       m_lfd;
    int         done_seen;

    router_fifo #(.DEPTH(16), .WIDTH(8), .ADDR_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .pkt_cnt    (pkt_cnt),
        .pkt_done   (pkt_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data_out"}, 32'(data_out), 32'(exp_data));
        check({tag, ".pkt_cnt"},  32'(pkt_cnt),  32'(exp_cnt));
        check({tag, ".pkt_done"}, 32'(pkt_done), 32'(exp_done));
        check({tag, ".empty"},    32'(empty),    32'(sb.size() == 0));
        check({tag, ".full"},     32'(full),     32'(sb.size() == 16));
    endtask

    task automatic model_clear();
        sb.delete();
        exp_data = 8'h00;
        exp_cnt  = 7'd0;
        exp_done = 1'b0;
        m_lfd    = 1'b0;
    endtask

    // One clock cycle of stimulus; the model decides acceptance from pre-edge occupancy.
    task automatic step(input string tag, input bit we, input bit re, input bit lfd, input logic [7:0] din);
        bit         wr_ok;
        bit         rd_ok;
        logic [8:0] e;
        write_enb = we;
        read_enb  = re;
        lfd_state = lfd;
        data_in   = din;
        wr_ok     = we && (sb.size() != 16);
        rd_ok     = re && (sb.size() != 0);
        exp_done  = 1'b0;
        if (rd_ok) begin
            e        = sb.pop_front();
            exp_data = e[7:0];
            if (e[8]) begin
                exp_cnt = {1'b0, e[7:2]} + 7'd1;
            end else if (exp_cnt != 7'd0) begin
                exp_cnt  = exp_cnt - 7'd1;
                exp_done = (exp_cnt == 7'd0);
            end
        end
        if (wr_ok) sb.push_back({m_lfd, din});
        m_lfd = lfd;
        @(posedge clk);
        #1;
        if (pkt_done) done_seen++;
        check_all(tag);
    endtask

    task automatic flush(input string tag, input bit hard, input int cycles);
        write_enb = 1'b0;
        read_enb  = 1'b0;
        lfd_state = 1'b0;
        if (hard) reset = 1'b1; else soft_reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset      = 1'b0;
        soft_reset = 1'b0;
        model_clear();
        check_all(tag);
    endtask

    initial begin
        logic [7:0] par;
        reset      = 1'b0;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;
        done_seen  = 0;
        model_clear();

        // Reset, then reads while empty must change nothing.
        flush("reset", 1'b1, 2);
        step("rd_empty0", 1'b0, 1'b1, 1'b0, 8'h00);
        step("rd_empty1", 1'b0, 1'b1, 1'b0, 8'h00);

        // Single packet: header 0x22 (len 8), 8 payload bytes, XOR parity.
        step("pk_lfd", 1'b0, 1'b0, 1'b1, 8'h00);
        step("pk_hdr", 1'b1, 1'b0, 1'b0, 8'h22);
        par = 8'h22;
        for (int i = 0; i < 8; i++) begin
            step("pk_pay", 1'b1, 1'b0, 1'b0, 8'hA0 + 8'(i));
            par = par ^ (8'hA0 + 8'(i));
        end
        step("pk_par", 1'b1, 1'b0, 1'b0, par);
        step("pk_rd_hdr", 1'b0, 1'b1, 1'b0, 8'h00);
        check("pk_cnt_after_hdr", 32'(pkt_cnt), 32'd9);
        done_seen = 0;
        for (int i = 0; i < 9; i++) step("pk_rd", 1'b0, 1'b1, 1'b0, 8'h00);
        check("pk_done_pulses", 32'(done_seen), 32'd1);
        check("pk_done_last", 32'(pkt_done), 32'd1);
        check("pk_parity_out", 32'(data_out), 32'(par));

        // Full boundary: 17 writes, the last one dropped.
        for (int i = 0; i <= 16; i++) step("full_wr", 1'b1, 1'b0, 1'b0, 8'(i));
        check("full_set", 32'(full), 32'd1);
        step("full_rdwr", 1'b1, 1'b1, 1'b0, 8'h99);
        check("full_rdwr_data", 32'(data_out), 32'h00);
        check("full_rdwr_full", 32'(full), 32'd0);
        for (int i = 0; i < 15; i++) step("full_rd", 1'b0, 1'b1, 1'b0, 8'h00);
        check("full_last", 32'(data_out), 32'h0F);
        check("full_empty", 32'(empty), 32'd1);

        // Simultaneous at empty: write accepted, data_out holds.
        step("empty_rdwr", 1'b1, 1'b1, 1'b0, 8'h77);
        check("empty_rdwr_hold", 32'(data_out), 32'h0F);
        step("empty_rdwr_rd", 1'b0, 1'b1, 1'b0, 8'h00);
        check("empty_rdwr_val", 32'(data_out), 32'h77);

        // Wrap-around batches of 10 and 12.
        for (int i = 0; i < 10; i++) step("wrap_wr10", 1'b1, 1'b0, 1'b0, 8'h30 + 8'(i));
        for (int i = 0; i < 10; i++) step("wrap_rd10", 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 12; i++) step("wrap_wr12", 1'b1, 1'b0, 1'b0, 8'h50 + 8'(i));
        for (int i = 0; i < 12; i++) step("wrap_rd12", 1'b0, 1'b1, 1'b0, 8'h00);
        check("wrap_last", 32'(data_out), 32'h5B);

        // Soft reset mid-packet.
        step("sr_lfd", 1'b0, 1'b0, 1'b1, 8'h00);
        step("sr_hdr", 1'b1, 1'b0, 1'b0, 8'h20);
        for (int i = 0; i < 9; i++) step("sr_pay", 1'b1, 1'b0, 1'b0, 8'hC0 + 8'(i));
        for (int i = 0; i < 4; i++) step("sr_rd", 1'b0, 1'b1, 1'b0, 8'h00);
        check("sr_cnt_before", 32'(pkt_cnt), 32'd6);
        flush("soft_reset", 1'b0, 1);
        check("sr_data_zero", 32'(data_out), 32'h00);

        // Length-0 packet after the flush.
        step("z_lfd", 1'b0, 1'b0, 1'b1, 8'h00);
        step("z_hdr", 1'b1, 1'b0, 1'b0, 8'h01);
        step("z_par", 1'b1, 1'b0, 1'b0, 8'h01);
        step("z_rd_hdr", 1'b0, 1'b1, 1'b0, 8'h00);
        check("z_cnt", 32'(pkt_cnt), 32'd1);
        step("z_rd_par", 1'b0, 1'b1, 1'b0, 8'h00);
        check("z_done", 32'(pkt_done), 32'd1);
        step("z_idle", 1'b0, 1'b0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
# router_fifo

Output buffer for one router port, downstream of `router_reg`. Each write stores one byte from `router_reg` together with a header flag, derived from `lfd_state` delayed one cycle to match `router_reg`'s output register. Reads return bytes in order. A packet counter, loaded from the header's length field, reports when the parity byte of each packet has left the FIFO. Three instances sit between `router_reg` and the three output ports.

## Interface
- `DEPTH`, 16, number of entries; must be a power of two.
- `WIDTH`, 8, data width; the stored word is WIDTH+1 bits (bit WIDTH is the header flag).
- `ADDR_W`, 4, log2(DEPTH); pointers are ADDR_W+1 bits.

- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high; clears all state.
- `soft_reset` input 1: synchronous, active-high flush (time-out); same effect as `reset`.
- `write_enb` input 1: write request for this cycle.
- `read_enb` input 1: read request for this cycle.
- `lfd_state` input 1: controller "load first data" state; registered internally as `lfd_q`.
- `data_in` input WIDTH: byte from `router_reg` (`dout`).
- `data_out` output WIDTH: registered read data.
- `full` output 1: all DEPTH entries occupied.
- `empty` output 1: no entries occupied.
- `pkt_cnt` output 7: bytes of the current packet still to be read.
- `pkt_done` output 1: one-cycle pulse as the last byte (parity) of a packet appears on `data_out`.

## Operation
- **Reset values.** `reset` or `soft_reset` sampled high sets:
  - `wr_ptr`=0, `rd_ptr`=0, `lfd_q`=0, `data_out`=0, `pkt_cnt`=0, `pkt_done`=0.
  - Resulting flags: `empty`=1, `full`=0.
  - Memory contents are not cleared; they are unobservable while empty.
  - Reset has priority over all other activity in that cycle.
- **`lfd_q`.** `lfd_q` <= `lfd_state` every cycle.
- **Write.** When `write_enb` && !`full`: mem[`wr_ptr`[ADDR_W-1:0]] <= {`lfd_q`, `data_in`}, then `wr_ptr`++. A write while full is dropped silently.
- **Read.** When `read_enb` && !`empty`: `data_out` <= mem[`rd_ptr`][WIDTH-1:0], then `rd_ptr`++. A read while empty is ignored and `data_out` holds.
- **Flags.**
  - `empty` = (`wr_ptr` == `rd_ptr`).
  - `full` = (MSBs of the pointers differ) && (lower ADDR_W bits equal).
  - Both are combinational decodes of the registered pointers.
- **Wrap-around.** Pointers wrap modulo 2*DEPTH with no special handling.
- **Simultaneous read and write.** Each is qualified by the flags as they stood at the start of the cycle:
  - While full: the read proceeds, the write is dropped.
  - While empty: the write proceeds, the read is ignored.
  - Otherwise: both proceed and occupancy is unchanged.
- **Packet counter.** Applies on each successful read.
  - Entry has the header flag: `pkt_cnt` <= data[7:2] + 1 (payload length + parity). The header byte itself is not counted.
  - Entry has no flag and `pkt_cnt` != 0: `pkt_cnt` decrements. If the decrement is 1 -> 0, `pkt_done` <= 1.
  - Entry has no flag and `pkt_cnt` == 0 (orphan byte): data is delivered, `pkt_cnt` stays 0, no `pkt_done`.
  - A header arriving while `pkt_cnt` != 0 reloads the counter. The previous packet is abandoned with no `pkt_done`.
  - Length 0: `pkt_cnt` loads 1, so the next byte is the parity byte.
- **`pkt_done`.** Is 0 in every cycle not listed above.
- **Idle cycles.** With no read, `data_out` holds its last value.

## Timing
- Write-to-flag latency: 1 cycle. `empty` deasserts the cycle after the first write is sampled.
- Read latency: 1 cycle. `data_out` shows the entry on the cycle after `read_enb` is sampled with !`empty`.
- `pkt_done` is registered and coincides with the parity byte on `data_out`.
- Header flag alignment: `lfd_state` high in cycle N flags the write performed in cycle N+1.
- Back-to-back reads: one byte per cycle; no bubble on a header/payload boundary.
- Full throughput: one write and one read per cycle, indefinitely, while neither flag blocks.

## Test plan
- **Reset.** Assert `reset` for 2 cycles. Expect `empty`=1, `full`=0, `data_out`=0x00, `pkt_cnt`=0, `pkt_done`=0. Reads issued while empty change nothing.
- **Single packet.**
  - Stimulus: `lfd_state`=1 for one cycle, then write header 0x22 (len 8), 8 payload bytes and the XOR parity (10 writes); then read 10.
  - Expect `data_out` to match in order.
  - Expect `pkt_cnt`=9 after the header read, decrementing to 0.
  - Expect `pkt_done`=1 for exactly the parity-byte cycle.
- **Full boundary.** Write 0x00–0x10 (17 writes) without reading.
  - Expect `full`=1 after the 16th write; 0x10 is dropped.
  - Read 16: expect 0x00–0x0F, with `empty`=1 after the last.
- **Simultaneous access.**
  - At full, `read_enb`=`write_enb`=1 for one cycle: the oldest byte is read, the write is dropped, occupancy becomes 15, `full`=0.
  - At empty: the write is accepted, `data_out` is unchanged.
- **Wrap-around.** Write/read 10, then write/read 12 (pointers cross DEPTH).
  - Expect data order preserved.
  - Expect `full` never asserted; `empty` after each batch.
- **soft_reset mid-packet.**
  - Stimulus: after reading the header and 3 payload bytes of a len-8 packet, pulse `soft_reset`.
  - Expect next cycle: `empty`=1, `pkt_cnt`=0, `data_out`=0x00, no `pkt_done`.
  - A following len-0 packet (header 0x01 plus parity) yields `pkt_done` on its parity byte.
